imu_stat_mon: RTL and testbench
===============================

IMU_STAT_MON -- requirements
Module: imu_stat_mon

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter NUM_CH, default 3: number of IMU channels, range 1..8.
REQ-003 SHALL have parameter SEQ_LEN, default 16: samples per statistics window, power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT, default 1024: idle cycles before a stall is flagged, at least 2.
REQ-005 SHALL use one clock, clk; reset is asynchronous and active-high, named rst.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- imu_data, in, DATA_WIDTH: sample.
- imu_ch, in, CW = max(1, clog2(NUM_CH)): channel tag.
- imu_valid, in, 1: sample strobe.
- stat_valid, out, 1: statistics record pending.
- stat_ready, in, 1: consumer accepts the record.
- stat_ch, out, CW: channel of the record.
- stat_min, out, DATA_WIDTH: window minimum.
- stat_max, out, DATA_WIDTH: window maximum.
- stat_sum, out, DATA_WIDTH + clog2(SEQ_LEN): signed window sum.
- stat_seq, out, 16: global record sequence number.
- sample_count, out, 32: total accepted samples.
- ovf_flag, out, 1: sticky, a record was dropped.
- stall_flag, out, 1: sticky, an idle timeout occurred.
- err_ch_flag, out, 1: sticky, imu_ch was at or above NUM_CH.

Function
REQ-007 SHALL accept every cycle in which imu_valid=1 and imu_ch<NUM_CH; there is no input backpressure.
REQ-008 SHALL ignore samples with imu_ch>=NUM_CH and set err_ch_flag the following cycle.
REQ-009 SHALL keep per-channel state: fill counter (0..SEQ_LEN-1), running min, running max, and sign-extended running sum.
REQ-010 On the first sample of a window (fill=0), SHALL load min=max=sum=sample; later samples SHALL update min and max by signed compare and add to sum.
REQ-011 When the SEQ_LEN-th sample of a channel is accepted, SHALL finalise that window, wrap fill to 0, and present the record with stat_valid=1 on the next cycle (latency 1).
REQ-012 stat_* outputs SHALL remain stable while stat_valid=1 and stat_ready=0; the record is consumed on the cycle with stat_valid and stat_ready both 1.
REQ-013 When a window completes while stat_valid=1 and stat_ready=0, SHALL drop the new record, set ovf_flag, and still restart that channel's window.
REQ-014 When a window completes in the same cycle the pending record is consumed, SHALL load the new record with no overflow.
REQ-015 stat_seq SHALL increment by 1, wrapping at 2^16, for each record loaded; dropped records SHALL NOT advance it.
REQ-016 sample_count SHALL increment per accepted sample and saturate at 2^32-1.
REQ-017 An idle counter SHALL clear on every accepted sample and count otherwise; when it reaches TIMEOUT, stall_flag SHALL set and the counter SHALL hold.
REQ-018 Only one sample per cycle exists, so per-channel updates never collide; state of other channels SHALL be unaffected.

Reset
REQ-019 rst=1 SHALL asynchronously clear all of the following to 0: fill counters, min/max/sum, stat_valid, all stat_* outputs, sample_count, idle counter, and all sticky flags.
REQ-020 Reset mid-window SHALL discard partial windows; the first sample after release starts a new window on every channel.
REQ-021 Sticky flags SHALL clear only on reset.

Configuration
REQ-022 Macro IMU_STAT_MON_RANGE_CHK_EN, when defined, SHALL add parameter RANGE_LIM (default 16000), output range_err (1 bit, sticky), and output range_cnt (16 bits, saturating).
REQ-023 With the macro defined, each accepted sample with |sample| > RANGE_LIM SHALL set range_err and increment range_cnt, and SHALL still enter the statistics.
REQ-024 Without the macro, those ports and that logic SHALL be absent; all other behaviour is identical.

Verification
REQ-025 NUM_CH=3, SEQ_LEN=4; channel 0 samples -5, 7, 2, -9 with stat_ready=1 -> one cycle later stat_valid=1, stat_ch=0, min=-9, max=7, sum=-5, stat_seq=0.
REQ-026 Interleave channels 1 and 2, each with 4 samples of 100; hold stat_ready=0 -> first record held stable, second dropped, ovf_flag=1, stat_seq stays 0.
REQ-027 Record pending; stat_ready=1 in the same cycle another window completes -> new record loaded, ovf_flag=0, stat_seq increments by 1.
REQ-028 imu_ch=3 with NUM_CH=3 -> err_ch_flag=1; sample_count unchanged; no channel state altered.
REQ-029 No valid input for TIMEOUT cycles -> stall_flag=1; assert rst asynchronously mid-window -> all outputs 0 immediately, and the next 4 samples form a fresh window.
REQ-030 With IMU_STAT_MON_RANGE_CHK_EN and RANGE_LIM=1000, samples 999, -1001, 1001 -> range_cnt=2, range_err=1.

Source files
------------

// File: rtl/imu_stat_mon.sv
// rtl/imu_stat_mon.sv - per-channel IMU window min/max/sum monitor with overflow, stall and channel-error flags
// Optional |sample| range checker is compiled in with IMU_STAT_MON_RANGE_CHK_EN.
module imu_stat_mon #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 3,
  parameter int SEQ_LEN    = 16,
  parameter int TIMEOUT    = 1024,
`ifdef IMU_STAT_MON_RANGE_CHK_EN
  parameter int RANGE_LIM  = 16000,
`endif
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int FW = $clog2(SEQ_LEN),
  localparam int SW = DATA_WIDTH + FW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] imu_data,
  input  logic [CW-1:0]         imu_ch,
  input  logic                  imu_valid,
  output logic                  stat_valid,
  input  logic                  stat_ready,
  output logic [CW-1:0]         stat_ch,
  output logic [DATA_WIDTH-1:0] stat_min,
  output logic [DATA_WIDTH-1:0] stat_max,
  output logic [SW-1:0]         stat_sum,
  output logic [15:0]           stat_seq,
  output logic [31:0]           sample_count,
  output logic                  ovf_flag,
  output logic                  stall_flag,
`ifdef IMU_STAT_MON_RANGE_CHK_EN
  output logic                  range_err,
  output logic [15:0]           range_cnt,
`endif
  output logic                  err_ch_flag
);

  localparam int              IW        = $clog2(TIMEOUT + 1);
  localparam logic [CW:0]     NUM_CH_L  = (CW + 1)'(NUM_CH);
  localparam logic [FW-1:0]   LAST_FILL = FW'(SEQ_LEN - 1);
  localparam logic [IW-1:0]   TIMEOUT_L = IW'(TIMEOUT);

  logic        [FW-1:0]         fill_q [NUM_CH];
  logic signed [DATA_WIDTH-1:0] min_q  [NUM_CH];
  logic signed [DATA_WIDTH-1:0] max_q  [NUM_CH];
  logic signed [SW-1:0]         sum_q  [NUM_CH];

  logic                         stat_valid_q, stat_valid_d;
  logic        [CW-1:0]         stat_ch_q;
  logic signed [DATA_WIDTH-1:0] stat_min_q, stat_max_q;
  logic signed [SW-1:0]         stat_sum_q;
  logic        [15:0]           stat_seq_q, seq_next_q;
  logic        [31:0]           count_q, count_d;
  logic        [IW-1:0]         idle_q, idle_d;
  logic                         ovf_q, ovf_d;
  logic                         stall_q, stall_d;
  logic                         err_q, err_d;

  logic                         ch_ok, accept, first, win_done, load, drop;
  logic signed [DATA_WIDTH-1:0] sample, cur_min, cur_max, upd_min, upd_max;
  logic signed [SW-1:0]         sample_ext, cur_sum, upd_sum;
  logic        [FW-1:0]         cur_fill, upd_fill;

  assign sample = imu_data;

  always_comb begin
    ch_ok      = ({1'b0, imu_ch} < NUM_CH_L);
    accept     = imu_valid && ch_ok;
    cur_fill   = fill_q[imu_ch];
    cur_min    = min_q[imu_ch];
    cur_max    = max_q[imu_ch];
    cur_sum    = sum_q[imu_ch];
    sample_ext = {{(SW - DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
    first      = (cur_fill == '0);
    upd_min    = (first || (sample < cur_min)) ? sample : cur_min;
    upd_max    = (first || (sample > cur_max)) ? sample : cur_max;
    upd_sum    = first ? sample_ext : (cur_sum + sample_ext);
    upd_fill   = (cur_fill == LAST_FILL) ? '0 : (cur_fill + 1'b1);
    win_done   = accept && (cur_fill == LAST_FILL);
    // A slot frees up in the same cycle the pending record is taken.
    load       = win_done && (!stat_valid_q || stat_ready);
    drop       = win_done && stat_valid_q && !stat_ready;
  end

  always_comb begin
    stat_valid_d = stat_valid_q;
    if (load) begin
      stat_valid_d = 1'b1;
    end else if (stat_valid_q && stat_ready) begin
      stat_valid_d = 1'b0;
    end

    count_d = count_q;
    if (accept && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end

    idle_d = idle_q;
    if (accept) begin
      idle_d = '0;
    end else if (idle_q != TIMEOUT_L) begin
      idle_d = idle_q + 1'b1;
    end

    ovf_d   = ovf_q | drop;
    stall_d = stall_q | (idle_d == TIMEOUT_L);
    err_d   = err_q | (imu_valid && !ch_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        fill_q[i] <= '0;
        min_q[i]  <= '0;
        max_q[i]  <= '0;
        sum_q[i]  <= '0;
      end
      stat_valid_q <= 1'b0;
      stat_ch_q    <= '0;
      stat_min_q   <= '0;
      stat_max_q   <= '0;
      stat_sum_q   <= '0;
      stat_seq_q   <= '0;
      seq_next_q   <= '0;
      count_q      <= '0;
      idle_q       <= '0;
      ovf_q        <= 1'b0;
      stall_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        fill_q[imu_ch] <= upd_fill;
        min_q[imu_ch]  <= upd_min;
        max_q[imu_ch]  <= upd_max;
        sum_q[imu_ch]  <= upd_sum;
      end
      if (load) begin
        stat_ch_q  <= imu_ch;
        stat_min_q <= upd_min;
        stat_max_q <= upd_max;
        stat_sum_q <= upd_sum;
        stat_seq_q <= seq_next_q;
        seq_next_q <= seq_next_q + 16'd1;
      end
      stat_valid_q <= stat_valid_d;
      count_q      <= count_d;
      idle_q       <= idle_d;
      ovf_q        <= ovf_d;
      stall_q      <= stall_d;
      err_q        <= err_d;
    end
  end

  assign stat_valid   = stat_valid_q;
  assign stat_ch      = stat_ch_q;
  assign stat_min     = stat_min_q;
  assign stat_max     = stat_max_q;
  assign stat_sum     = stat_sum_q;
  assign stat_seq     = stat_seq_q;
  assign sample_count = count_q;
  assign ovf_flag     = ovf_q;
  assign stall_flag   = stall_q;
  assign err_ch_flag  = err_q;

`ifdef IMU_STAT_MON_RANGE_CHK_EN
  localparam int            AW          = DATA_WIDTH + 1;
  localparam logic [AW-1:0] RANGE_LIM_L = AW'(RANGE_LIM);

  logic [AW-1:0] sample_sx, abs_mag;
  logic          range_hit;
  logic          range_err_q, range_err_d;
  logic [15:0]   range_cnt_q, range_cnt_d;

  always_comb begin
    // One extra bit so the magnitude of the most negative sample fits.
    sample_sx   = {sample[DATA_WIDTH-1], sample};
    abs_mag     = sample_sx[AW-1] ? (~sample_sx + 1'b1) : sample_sx;
    range_hit   = accept && (abs_mag > RANGE_LIM_L);
    range_err_d = range_err_q | range_hit;
    range_cnt_d = range_cnt_q;
    if (range_hit && (range_cnt_q != 16'hFFFF)) begin
      range_cnt_d = range_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err_q <= 1'b0;
      range_cnt_q <= '0;
    end else begin
      range_err_q <= range_err_d;
      range_cnt_q <= range_cnt_d;
    end
  end

  assign range_err = range_err_q;
  assign range_cnt = range_cnt_q;
`endif

endmodule

// File: tb/tb_imu_stat_mon.sv
// tb/tb_imu_stat_mon.sv - directed table-driven bench for imu_stat_mon (NUM_CH=3, SEQ_LEN=4)
// Range checks are exercised when IMU_STAT_MON_RANGE_CHK_EN is defined.
module tb_imu_stat_mon;

  localparam int DW  = 16;
  localparam int NCH = 3;
  localparam int SL  = 4;
  localparam int TMO = 20;
  localparam int CW  = 2;
  localparam int SW  = DW + 2;
  localparam int NV  = 31;

  logic          clk;
  logic          rst;
  logic [DW-1:0] imu_data;
  logic [CW-1:0] imu_ch;
  logic          imu_valid;
  logic          stat_valid;
  logic          stat_ready;
  logic [CW-1:0] stat_ch;
  logic [DW-1:0] stat_min;
  logic [DW-1:0] stat_max;
  logic [SW-1:0] stat_sum;
  logic [15:0]   stat_seq;
  logic [31:0]   sample_count;
  logic          ovf_flag;
  logic          stall_flag;
  logic          err_ch_flag;
`ifdef IMU_STAT_MON_RANGE_CHK_EN
  logic          range_err;
  logic [15:0]   range_cnt;
`endif

  imu_stat_mon #(
    .DATA_WIDTH(DW),
    .NUM_CH(NCH),
    .SEQ_LEN(SL),
`ifdef IMU_STAT_MON_RANGE_CHK_EN
    .RANGE_LIM(1000),
`endif
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imu_data(imu_data),
    .imu_ch(imu_ch),
    .imu_valid(imu_valid),
    .stat_valid(stat_valid),
    .stat_ready(stat_ready),
    .stat_ch(stat_ch),
    .stat_min(stat_min),
    .stat_max(stat_max),
    .stat_sum(stat_sum),
    .stat_seq(stat_seq),
    .sample_count(sample_count),
    .ovf_flag(ovf_flag),
    .stall_flag(stall_flag),
`ifdef IMU_STAT_MON_RANGE_CHK_EN
    .range_err(range_err),
    .range_cnt(range_cnt),
`endif
    .err_ch_flag(err_ch_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v; int ch; int d; int rdy;
    int sv; int sch; int mn; int mx; int sm; int seq; int cnt; int ovf; int err;
  } vec_t;

  vec_t tbl [NV];
  int   n_cmp;
  int   n_err;

  function automatic vec_t mk(int v, int ch, int d, int rdy, int sv, int sch, int mn,
                              int mx, int sm, int seq, int cnt, int ovf, int err);
    vec_t r;
    r.v = v; r.ch = ch; r.d = d; r.rdy = rdy;
    r.sv = sv; r.sch = sch; r.mn = mn; r.mx = mx; r.sm = sm;
    r.seq = seq; r.cnt = cnt; r.ovf = ovf; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input int v, input int ch, input int d, input int rdy);
    imu_valid  = (v != 0);
    imu_ch     = CW'(ch);
    imu_data   = DW'(d);
    stat_ready = (rdy != 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //          v ch  data   rdy| sv sch  min     max    sum    seq cnt ovf err
    tbl[0]  = mk(1, 0,     -5, 1,  0, 0,      0,     0,      0, 0,  1, 0, 0);
    tbl[1]  = mk(1, 0,      7, 1,  0, 0,      0,     0,      0, 0,  2, 0, 0);
    tbl[2]  = mk(1, 0,      2, 1,  0, 0,      0,     0,      0, 0,  3, 0, 0);
    tbl[3]  = mk(1, 0,     -9, 1,  1, 0,     -9,     7,     -5, 0,  4, 0, 0);
    tbl[4]  = mk(1, 1,      1, 0,  1, 0,     -9,     7,     -5, 0,  5, 0, 0);
    tbl[5]  = mk(1, 1,      2, 0,  1, 0,     -9,     7,     -5, 0,  6, 0, 0);
    tbl[6]  = mk(1, 1,      3, 0,  1, 0,     -9,     7,     -5, 0,  7, 0, 0);
    tbl[7]  = mk(1, 1,     -4, 1,  1, 1,     -4,     3,      2, 1,  8, 0, 0);
    tbl[8]  = mk(0, 0,      0, 1,  0, 1,     -4,     3,      2, 1,  8, 0, 0);
    tbl[9]  = mk(1, 1,    100, 0,  0, 1,     -4,     3,      2, 1,  9, 0, 0);
    tbl[10] = mk(1, 2,    100, 0,  0, 1,     -4,     3,      2, 1, 10, 0, 0);
    tbl[11] = mk(1, 1,    100, 0,  0, 1,     -4,     3,      2, 1, 11, 0, 0);
    tbl[12] = mk(1, 2,    100, 0,  0, 1,     -4,     3,      2, 1, 12, 0, 0);
    tbl[13] = mk(1, 1,    100, 0,  0, 1,     -4,     3,      2, 1, 13, 0, 0);
    tbl[14] = mk(1, 2,    100, 0,  0, 1,     -4,     3,      2, 1, 14, 0, 0);
    tbl[15] = mk(1, 1,    100, 0,  1, 1,    100,   100,    400, 2, 15, 0, 0);
    tbl[16] = mk(1, 2,    100, 0,  1, 1,    100,   100,    400, 2, 16, 1, 0);
    tbl[17] = mk(0, 0,      0, 0,  1, 1,    100,   100,    400, 2, 16, 1, 0);
    tbl[18] = mk(1, 3,    555, 0,  1, 1,    100,   100,    400, 2, 16, 1, 1);
    tbl[19] = mk(0, 0,      0, 1,  0, 1,    100,   100,    400, 2, 16, 1, 1);
    tbl[20] = mk(1, 0,     50, 1,  0, 1,    100,   100,    400, 2, 17, 1, 1);
    tbl[21] = mk(1, 3,   -999, 1,  0, 1,    100,   100,    400, 2, 17, 1, 1);
    tbl[22] = mk(1, 0,     60, 1,  0, 1,    100,   100,    400, 2, 18, 1, 1);
    tbl[23] = mk(1, 0,     70, 1,  0, 1,    100,   100,    400, 2, 19, 1, 1);
    tbl[24] = mk(1, 0,     80, 1,  1, 0,     50,    80,    260, 3, 20, 1, 1);
    tbl[25] = mk(0, 0,      0, 1,  0, 0,     50,    80,    260, 3, 20, 1, 1);
    tbl[26] = mk(1, 2, -32768, 1,  0, 0,     50,    80,    260, 3, 21, 1, 1);
    tbl[27] = mk(1, 2,  32767, 1,  0, 0,     50,    80,    260, 3, 22, 1, 1);
    tbl[28] = mk(1, 2, -32768, 1,  0, 0,     50,    80,    260, 3, 23, 1, 1);
    tbl[29] = mk(1, 2, -32768, 1,  1, 2, -32768, 32767, -65537, 4, 24, 1, 1);
    tbl[30] = mk(0, 0,      0, 1,  0, 2, -32768, 32767, -65537, 4, 24, 1, 1);

    rst = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 0, longint'(stat_valid), 0);
    chk("rst_min",   0, longint'($signed(stat_min)), 0);
    chk("rst_sum",   0, longint'($signed(stat_sum)), 0);
    chk("rst_seq",   0, longint'(stat_seq), 0);
    chk("rst_count", 0, longint'(sample_count), 0);
    chk("rst_flags", 0, longint'({ovf_flag, stall_flag, err_ch_flag}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk("stat_valid",   i, longint'(stat_valid), longint'(tbl[i].sv));
      chk("stat_ch",      i, longint'(stat_ch), longint'(tbl[i].sch));
      chk("stat_min",     i, longint'($signed(stat_min)), longint'(tbl[i].mn));
      chk("stat_max",     i, longint'($signed(stat_max)), longint'(tbl[i].mx));
      chk("stat_sum",     i, longint'($signed(stat_sum)), longint'(tbl[i].sm));
      chk("stat_seq",     i, longint'(stat_seq), longint'(tbl[i].seq));
      chk("sample_count", i, longint'(sample_count), longint'(tbl[i].cnt));
      chk("ovf_flag",     i, longint'(ovf_flag), longint'(tbl[i].ovf));
      chk("err_ch_flag",  i, longint'(err_ch_flag), longint'(tbl[i].err));
    end

    // Idle timeout: one sample opens a window on ch0, then the bus goes quiet.
    drive(1, 0, 5, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1);
    chk("stall_start", 0, longint'(stall_flag), 0);
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("stall_early", 0, longint'(stall_flag), 0);
    @(posedge clk);
    #1;
    chk("stall_set", 0, longint'(stall_flag), 1);
    chk("stall_cnt", 0, longint'(sample_count), 25);

    // Asynchronous reset between clock edges, with ch0 partially filled.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 0, longint'(stat_valid), 0);
    chk("arst_ch",    0, longint'(stat_ch), 0);
    chk("arst_min",   0, longint'($signed(stat_min)), 0);
    chk("arst_max",   0, longint'($signed(stat_max)), 0);
    chk("arst_sum",   0, longint'($signed(stat_sum)), 0);
    chk("arst_seq",   0, longint'(stat_seq), 0);
    chk("arst_count", 0, longint'(sample_count), 0);
    chk("arst_flags", 0, longint'({ovf_flag, stall_flag, err_ch_flag}), 0);
`ifdef IMU_STAT_MON_RANGE_CHK_EN
    chk("arst_range", 0, longint'({range_err, range_cnt}), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, i, 1);
      @(posedge clk);
      #1;
      chk("fresh_valid", i, longint'(stat_valid), (i == 4) ? 1 : 0);
      chk("fresh_count", i, longint'(sample_count), longint'(i));
    end
    chk("fresh_ch",  0, longint'(stat_ch), 0);
    chk("fresh_min", 0, longint'($signed(stat_min)), 1);
    chk("fresh_max", 0, longint'($signed(stat_max)), 4);
    chk("fresh_sum", 0, longint'($signed(stat_sum)), 10);
    chk("fresh_seq", 0, longint'(stat_seq), 0);

`ifdef IMU_STAT_MON_RANGE_CHK_EN
    drive(1, 1, 999, 1);
    @(posedge clk);
    #1;
    chk("range_err_999", 0, longint'(range_err), 0);
    chk("range_cnt_999", 0, longint'(range_cnt), 0);
    drive(1, 1, -1001, 1);
    @(posedge clk);
    #1;
    chk("range_err_m1001", 0, longint'(range_err), 1);
    chk("range_cnt_m1001", 0, longint'(range_cnt), 1);
    drive(1, 1, 1001, 1);
    @(posedge clk);
    #1;
    chk("range_err_1001", 0, longint'(range_err), 1);
    chk("range_cnt_1001", 0, longint'(range_cnt), 2);
    chk("range_count",    0, longint'(sample_count), 7);
`endif

    drive(0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
